// File: rtl/ct_arith_pkg.sv
// Shared state encodings for the constant-time arithmetic units (divider and multiplier).
package ct_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_ACC  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/ct_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, mux the result.
module ct_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    assign shifted  = {rem, dvd_msb};
    assign trial    = {1'b0, shifted} - {2'b00, divisor};
    // Top two bits catch both borrow and overflow; with rem < divisor only borrow can occur.
    assign q_bit    = (trial[WIDTH+1:WIDTH] == 2'b00);
    assign next_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/const_time_divider.sv
// Constant-time restoring divider: every operation takes WIDTH CALC cycles regardless of operands.
// Build option CT_DIV_ZERO_FASTPATH_EN: divisor==0 skips CALC (intentionally timing-leaky variant).
module const_time_divider
    import ct_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             quotientDone,
    output logic             busy
);

    localparam int               CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    div_state_t       state, state_next;
    logic [WIDTH-1:0] dvd, dvs, rem, next_rem;
    logic [CNT_W-1:0] count;
    logic             q_bit, last_step, zero_fast;

`ifdef CT_DIV_ZERO_FASTPATH_EN
    assign zero_fast = (divisor == '0);
`else
    assign zero_fast = 1'b0;
`endif

    assign last_step = (count == LAST);

    ct_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .dvd_msb  (dvd[WIDTH-1]),
        .divisor  (dvs),
        .next_rem (next_rem),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Transitions depend only on start and the step counter, never on operand data.
    always_comb begin
        state_next   = state;
        busy         = (state != IDLE);
        quotientDone = (state == DONE);
        case (state)
            IDLE:    if (start) state_next = zero_fast ? DONE : CALC;
            CALC:    if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd   <= dividend;
                        dvs   <= divisor;
                        rem   <= '0;
                        count <= '0;
                        if (zero_fast) begin
                            quotient  <= '1;
                            remainder <= dividend;
                        end
                    end
                end
                CALC: begin
                    // The dividend register doubles as the quotient shift register.
                    rem   <= next_rem;
                    dvd   <= {dvd[WIDTH-2:0], q_bit};
                    count <= count + CNT_W'(1);
                    if (last_step) begin
                        quotient  <= {dvd[WIDTH-2:0], q_bit};
                        remainder <= next_rem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_const_time_divider.sv
// Self-checking bench for const_time_divider: directed table, multi-cycle corner cases, random vs. model.
module tb_const_time_divider;

    localparam int W = 8;
`ifdef CT_DIV_ZERO_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0, divisor = '0, dividend_b = '0, divisor_b = '0;
    logic [W-1:0] quotient, remainder, quotient_b, remainder_b;
    logic         done, done_b, busy, busy_b;

    int errors = 0;
    int checks = 0;
    int ecount = 0;
    int hits_a = 0, hits_b = 0, edge_a = 0, edge_b = 0;
    logic [W-1:0] q_a = '0, r_a = '0, q_b = '0, r_b = '0;

    typedef struct {
        logic [W-1:0] a, b, q, r;
        int           lat;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    const_time_divider #(.WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .quotientDone(done), .busy(busy)
    );

    const_time_divider #(.WIDTH(W)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend_b), .divisor(divisor_b),
        .quotient(quotient_b), .remainder(remainder_b), .quotientDone(done_b), .busy(busy_b)
    );

    always @(posedge clk) ecount <= ecount + 1;

    // Record every done pulse with the edge count and the results visible in that cycle.
    always @(negedge clk) begin
        if (done) begin
            hits_a <= hits_a + 1;
            edge_a <= ecount;
            q_a    <= quotient;
            r_a    <= remainder;
        end
        if (done_b) begin
            hits_b <= hits_b + 1;
            edge_b <= ecount;
            q_b    <= quotient_b;
            r_b    <= remainder_b;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division; divisor 0 gives all-ones / dividend.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
        if (b == '0) begin
            q   = '1;
            r   = a;
            lat = FAST ? 1 : W + 1;
        end else begin
            q   = a / b;
            r   = a % b;
            lat = W + 1;
        end
    endtask

    task automatic do_op(input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic [W-1:0] q0, input logic [W-1:0] r0, input int l0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1,
                         input logic [W-1:0] q1, input logic [W-1:0] r1, input int l1,
                         input bit aligned);
        int s, base_a, base_b;
        if (!aligned) @(negedge clk);
        start = 1'b1;
        dividend = a0; divisor = b0; dividend_b = a1; divisor_b = b1;
        base_a = hits_a; base_b = hits_b;
        @(posedge clk);
        #1;
        s = ecount;
        start = 1'b0;
        dividend = W'($urandom); divisor = W'($urandom);
        dividend_b = W'($urandom); divisor_b = W'($urandom);
        @(negedge clk);
        check("busy_during_op", int'(busy), 1);
        repeat (13) @(negedge clk);
        check("pulses_a", hits_a - base_a, 1);
        check("quot_a", int'(q_a), int'(q0));
        check("rem_a", int'(r_a), int'(r0));
        check("latency_a", edge_a - s + 1, l0);
        check("quot_hold_a", int'(quotient), int'(q0));
        check("rem_hold_a", int'(remainder), int'(r0));
        check("busy_idle_a", int'(busy), 0);
        check("pulses_b", hits_b - base_b, 1);
        check("quot_b", int'(q_b), int'(q1));
        check("rem_b", int'(r_b), int'(r1));
        check("latency_b", edge_b - s + 1, l1);
        check("coincide", int'(edge_a == edge_b), int'(l0 == l1));
        if (edge_a != edge_b)
            $display("note: timing leak observed, done edges a=%0d b=%0d", edge_a - s + 1, edge_b - s + 1);
    endtask

    logic [W-1:0] ra, rb, rq, rr, ra2, rb2, rq2, rr2;
    int           rl, rl2, s0, base0;
    bit           found;

    initial begin
        vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   W + 1};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   W + 1};
        vecs[2] = '{8'd3,   8'd200, 8'd0,   8'd3,   W + 1};
        vecs[3] = '{8'd5,   8'd0,   8'd255, 8'd5,   FAST ? 1 : W + 1};
        vecs[4] = '{8'd0,   8'd5,   8'd0,   8'd0,   W + 1};
        vecs[5] = '{8'd255, 8'd255, 8'd1,   8'd0,   W + 1};
        vecs[6] = '{8'd254, 8'd255, 8'd0,   8'd254, W + 1};
        vecs[7] = '{8'd200, 8'd9,   8'd22,  8'd2,   W + 1};

        // Asynchronous reset with the clock still low.
        #2 rst = 1'b0;
        #2;
        check("reset_quot", int'(quotient), 0);
        check("reset_rem", int'(remainder), 0);
        check("reset_done", int'(done), 0);
        check("reset_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].lat,
                  8'd1, 8'd1, 8'd1, 8'd0, W + 1, 1'b0);

        // Second start at edge 4 of an operation must be ignored.
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        base0 = hits_a;
        @(posedge clk);
        #1 s0 = ecount;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 start = 1'b1; dividend = 8'd200; divisor = 8'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (14) @(negedge clk);
        check("restart_pulses", hits_a - base0, 1);
        check("restart_quot", int'(q_a), 14);
        check("restart_rem", int'(r_a), 2);
        check("restart_latency", edge_a - s0 + 1, W + 1);

        // Start held through DONE: ignored in DONE, accepted the cycle after.
        @(negedge clk);
        start = 1'b1; dividend = 8'd60; divisor = 8'd7;
        @(posedge clk);
        #1 start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        check("done_seen", int'(found), 1);
        check("done_cycle_quot", int'(quotient), 8);
        check("done_cycle_rem", int'(remainder), 4);
        start = 1'b1; dividend = 8'd90; divisor = 8'd4;
        @(posedge clk);
        #1;
        check("start_in_done_ignored", int'(busy), 0);
        base0 = hits_a;
        @(posedge clk);
        #1 s0 = ecount;
        start = 1'b0;
        check("start_after_done_accepted", int'(busy), 1);
        repeat (14) @(negedge clk);
        check("after_done_pulses", hits_a - base0, 1);
        check("after_done_quot", int'(q_a), 22);
        check("after_done_rem", int'(r_a), 2);
        check("after_done_latency", edge_a - s0 + 1, W + 1);

        // Reset at edge 5 aborts the operation without a done pulse.
        @(negedge clk);
        start = 1'b1; dividend = 8'd255; divisor = 8'd1;
        base0 = hits_a;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_quot", int'(quotient), 0);
        check("abort_rem", int'(remainder), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        repeat (3) @(negedge clk);
        check("abort_no_pulse", hits_a - base0, 0);
        rst = 1'b1;
        do_op(8'd200, 8'd9, 8'd22, 8'd2, W + 1, 8'd6, 8'd3, 8'd2, 8'd0, W + 1, 1'b1);

        // Random operand pairs on both instances against the reference model.
        for (int i = 0; i < 1200; i++) begin
            ra  = W'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            ra2 = W'($urandom);
            rb2 = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            model(ra, rb, rq, rr, rl);
            model(ra2, rb2, rq2, rr2, rl2);
            do_op(ra, rb, rq, rr, rl, ra2, rb2, rq2, rr2, rl2, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
